// File: rtl/ram_burst_reader.sv
// ram_burst_reader
// ----------------
// Read-side burst engine for one port of a 64x8 dual-port RAM. A start
// command with a word count reads consecutive RAM words (the address wraps
// at the top of the RAM) and streams them out on a valid/ready interface.
// A 2-entry output buffer sustains one word per cycle while the sink is
// ready and loses nothing under backpressure.
//
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   start              burst request, sampled only while busy=0
//   start_addr, len    first address and word count (0..2**ADDR_W)
//   busy, done         burst in progress / one-cycle completion pulse
//   ram_addr, ram_we   RAM port address and write enable (always 0)
//   ram_q              RAM read data, valid one cycle after its address
//   m_data, m_valid,   output stream
//   m_ready
//   chk                XOR of every word handshaken in the current burst
//                      (only with RAM_BURST_CHECKSUM_EN defined)
//
// Optional feature macro: RAM_BURST_CHECKSUM_EN adds the chk output.

module ram_burst_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
`ifdef RAM_BURST_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] chk
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t state_reg, state_next;

  logic [ADDR_W-1:0] addr_cnt_reg;   // next address to issue
  logic [ADDR_W-1:0] ram_addr_reg;   // last address presented to the RAM
  logic [ADDR_W:0]   issue_cnt_reg;  // reads still to issue
  logic [ADDR_W:0]   ret_cnt_reg;    // words still to hand off downstream
  logic              inflight_reg;   // a read was issued last cycle
  logic [1:0]        count_reg;      // words held in the output buffer
  logic [DATA_W-1:0] buf0_reg;       // buffer head, drives m_data
  logic [DATA_W-1:0] buf1_reg;

  logic       accept;
  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ_after_pop;

  // Buffer slots already spoken for: held words plus the read whose data
  // lands at the coming edge. A read is only issued if, after this cycle's
  // pop, a slot is still free for its data, so the buffer can never overflow.
  always_comb begin
    accept        = (state_reg == ST_IDLE) && start;
    m_valid       = (count_reg != 2'd0);
    m_data        = buf0_reg;
    pop           = m_valid && m_ready;
    push          = inflight_reg;
    occ_after_pop = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    issue         = (state_reg == ST_RUN) && (issue_cnt_reg != '0) &&
                    (occ_after_pop < 3'd2);
    // The port shows the address being issued and holds it otherwise.
    ram_addr      = issue ? addr_cnt_reg : ram_addr_reg;
    ram_we        = 1'b0;
    busy          = (state_reg != ST_IDLE);
    done          = (state_reg == ST_FIN);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (len == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (pop && (ret_cnt_reg == CNT_ONE)) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_cnt_reg  <= '0;
      ram_addr_reg  <= '0;
      issue_cnt_reg <= '0;
      ret_cnt_reg   <= '0;
      inflight_reg  <= 1'b0;
      count_reg     <= 2'd0;
      buf0_reg      <= '0;
      buf1_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      ram_addr_reg <= ram_addr;
      inflight_reg <= issue;

      if (accept) begin
        addr_cnt_reg  <= start_addr;
        issue_cnt_reg <= len;
        ret_cnt_reg   <= len;
      end else begin
        if (issue) begin
          addr_cnt_reg  <= addr_cnt_reg + ADDR_ONE;  // wraps at the RAM top
          issue_cnt_reg <= issue_cnt_reg - CNT_ONE;
        end
        if (pop) begin
          ret_cnt_reg <= ret_cnt_reg - CNT_ONE;
        end
      end

      // RAM data for last cycle's read is on ram_q now; the head register
      // always holds the oldest word, the second slot the next one.
      case ({push, pop})
        2'b10: begin
          if (count_reg == 2'd0) begin
            buf0_reg <= ram_q;
          end else begin
            buf1_reg <= ram_q;
          end
          count_reg <= count_reg + 2'd1;
        end
        2'b01: begin
          buf0_reg  <= buf1_reg;
          count_reg <= count_reg - 2'd1;
        end
        2'b11: begin
          if (count_reg == 2'd1) begin
            buf0_reg <= ram_q;
          end else begin
            buf0_reg <= buf1_reg;
            buf1_reg <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_BURST_CHECKSUM_EN
  logic [DATA_W-1:0] chk_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_reg <= '0;
    end else if (accept) begin
      chk_reg <= '0;
    end else if (pop) begin
      chk_reg <= chk_reg ^ buf0_reg;
    end
  end

  assign chk = chk_reg;
`endif

endmodule
